// File: rtl/bfm_apb_pkg.sv
// Shared types and helpers for the APB fan-out bridge BFM.
package bfm_apb_pkg;

  // Bridge FSM: one upstream transfer in flight at a time.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Width of the slot field carved out of the address, and the most
  // slots that field can name.
  localparam int unsigned SLOT_W    = 4;
  localparam int unsigned MAX_SLOTS = 16;

  // Ceiling log2, used to size the wait-state counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bfm_apb_wait_timer.sv
// Counts downstream wait cycles in ACCESS and flags the last cycle the
// bridge will wait before aborting. TIMEOUT=0 turns the flag off entirely.
module bfm_apb_wait_timer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment; frozen when timeouts are off.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (TIMEOUT != 0)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The counter holds k-2 on ACCESS edge Ek, so reaching TIMEOUT-1 means
  // this is the TIMEOUT-th ACCESS edge without a ready.
  if (TIMEOUT == 0) begin : g_no_timeout
    assign term_o = 1'b0;
  end else begin : g_timeout
    assign term_o = (cnt_q == CNT_W'(TIMEOUT - 1));
  end

endmodule

// File: rtl/bfm_apb_fanout.sv
// APB3 bridge BFM: takes one upstream transfer, decodes a 4-bit slot field
// from the address and replays the transfer on that downstream slot.
// Unmapped slots answer with an error; stuck slaves are aborted by timeout.
module bfm_apb_fanout
  import bfm_apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NSLOTS  = 16,
  parameter int unsigned SEL_LSB = 24,
  parameter logic [15:0] SLOT_EN = 16'hFFFF,
  parameter int unsigned TIMEOUT = 255,
  parameter int          TPD     = 1
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     PSEL_PM,
  input  logic                     PENABLE_PM,
  input  logic                     PWRITE_PM,
  input  logic [ADDR_W-1:0]        PADDR_PM,
  input  logic [DATA_W-1:0]        PWDATA_PM,
  output logic [DATA_W-1:0]        PRDATA_PM,
  output logic                     PREADY_PM,
  output logic                     PSLVERR_PM,
  output logic [NSLOTS-1:0]        PSEL_SC,
  output logic [ADDR_W-1:0]        PADDR_SC,
  output logic                     PWRITE_SC,
  output logic                     PENABLE_SC,
  output logic [DATA_W-1:0]        PWDATA_SC,
  input  logic [NSLOTS*DATA_W-1:0] PRDATA_SC,
  input  logic [NSLOTS-1:0]        PREADY_SC,
  input  logic [NSLOTS-1:0]        PSLVERR_SC,
  output logic                     TIMEOUT_O,
  output logic                     DECERR_O
);

  localparam int unsigned CNT_W = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);

  // TPD describes board-level output delay for behavioural models; every
  // output here comes straight from a register, so it shapes no logic.
  if (TPD < 0) begin : g_tpd_negative
  end

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [NSLOTS-1:0]   psel_sc_q, psel_sc_d;
  logic [ADDR_W-1:0]   paddr_sc_q, paddr_sc_d;
  logic                pwrite_sc_q, pwrite_sc_d;
  logic                penable_sc_q, penable_sc_d;
  logic [DATA_W-1:0]   pwdata_sc_q, pwdata_sc_d;
  logic [DATA_W-1:0]   prdata_pm_q, prdata_pm_d;
  logic                pready_pm_q, pready_pm_d;
  logic                pslverr_pm_q, pslverr_pm_d;
  logic                timeout_q, timeout_d;
  logic                decerr_q, decerr_d;

  // Slot decode of the incoming setup address.
  logic [SLOT_W-1:0]   slot_in;
  logic                slot_valid;
  logic [NSLOTS-1:0]   onehot_in;

  assign slot_in    = PADDR_PM[SEL_LSB +: SLOT_W];
  assign slot_valid = (32'(slot_in) < NSLOTS) && SLOT_EN[slot_in];

  // Per-slot responses padded to the full 16 so the 4-bit slot index is
  // always in range, whatever NSLOTS is.
  logic [MAX_SLOTS-1:0] ready_pad;
  logic [MAX_SLOTS-1:0] err_pad;
  logic [DATA_W-1:0]    rdata_pad [MAX_SLOTS];

  for (genvar gi = 0; gi < MAX_SLOTS; gi++) begin : g_slot
    if (gi < NSLOTS) begin : g_used
      assign onehot_in[gi] = (slot_in == SLOT_W'(gi));
      assign ready_pad[gi] = PREADY_SC[gi];
      assign err_pad[gi]   = PSLVERR_SC[gi];
      assign rdata_pad[gi] = PRDATA_SC[gi*DATA_W +: DATA_W];
    end else begin : g_unused
      assign ready_pad[gi] = 1'b0;
      assign err_pad[gi]   = 1'b0;
      assign rdata_pad[gi] = '0;
    end
  end

  logic sel_ready;
  logic timer_term;

  assign sel_ready = ready_pad[slot_q];

  bfm_apb_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clk_i  (PCLK),
    .srst_i (PRESET),
    .clr_i  (state_q != ST_ACCESS),
    .en_i   ((state_q == ST_ACCESS) && !sel_ready),
    .term_o (timer_term)
  );

  // Next-state logic: downstream outputs only carry values in SETUP/ACCESS,
  // upstream read data and error hold until the next response.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    psel_sc_d    = psel_sc_q;
    paddr_sc_d   = paddr_sc_q;
    pwrite_sc_d  = pwrite_sc_q;
    penable_sc_d = penable_sc_q;
    pwdata_sc_d  = pwdata_sc_q;
    prdata_pm_d  = prdata_pm_q;
    pslverr_pm_d = pslverr_pm_q;
    pready_pm_d  = 1'b0;
    timeout_d    = 1'b0;
    decerr_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (PSEL_PM && !PENABLE_PM) begin
          if (slot_valid) begin
            state_d      = ST_SETUP;
            slot_d       = slot_in;
            psel_sc_d    = onehot_in;
            paddr_sc_d   = PADDR_PM;
            pwrite_sc_d  = PWRITE_PM;
            pwdata_sc_d  = PWDATA_PM;
            penable_sc_d = 1'b0;
          end else begin
            state_d      = ST_RESP;
            pready_pm_d  = 1'b1;
            pslverr_pm_d = 1'b1;
            prdata_pm_d  = '0;
            decerr_d     = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        state_d      = ST_ACCESS;
        penable_sc_d = 1'b1;
      end
      ST_ACCESS: begin
        if (sel_ready || timer_term) begin
          state_d      = ST_RESP;
          pready_pm_d  = 1'b1;
          psel_sc_d    = '0;
          paddr_sc_d   = '0;
          pwrite_sc_d  = 1'b0;
          penable_sc_d = 1'b0;
          pwdata_sc_d  = '0;
          if (sel_ready) begin
            prdata_pm_d  = rdata_pad[slot_q];
            pslverr_pm_d = err_pad[slot_q];
          end else begin
            prdata_pm_d  = '0;
            pslverr_pm_d = 1'b1;
            timeout_d    = 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything in one edge.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      psel_sc_q    <= '0;
      paddr_sc_q   <= '0;
      pwrite_sc_q  <= 1'b0;
      penable_sc_q <= 1'b0;
      pwdata_sc_q  <= '0;
      prdata_pm_q  <= '0;
      pready_pm_q  <= 1'b0;
      pslverr_pm_q <= 1'b0;
      timeout_q    <= 1'b0;
      decerr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      psel_sc_q    <= psel_sc_d;
      paddr_sc_q   <= paddr_sc_d;
      pwrite_sc_q  <= pwrite_sc_d;
      penable_sc_q <= penable_sc_d;
      pwdata_sc_q  <= pwdata_sc_d;
      prdata_pm_q  <= prdata_pm_d;
      pready_pm_q  <= pready_pm_d;
      pslverr_pm_q <= pslverr_pm_d;
      timeout_q    <= timeout_d;
      decerr_q     <= decerr_d;
    end
  end

  assign PSEL_SC    = psel_sc_q;
  assign PADDR_SC   = paddr_sc_q;
  assign PWRITE_SC  = pwrite_sc_q;
  assign PENABLE_SC = penable_sc_q;
  assign PWDATA_SC  = pwdata_sc_q;
  assign PRDATA_PM  = prdata_pm_q;
  assign PREADY_PM  = pready_pm_q;
  assign PSLVERR_PM = pslverr_pm_q;
  assign TIMEOUT_O  = timeout_q;
  assign DECERR_O   = decerr_q;

endmodule

// File: doc/bfm_apb_fanout.md
# bfm_apb_fanout

Parametrised single-clock APB bridge bus-functional model: accepts one APB3 transfer at a time from an upstream master port and replays it on one of up to 16 downstream slave slots. Slot decode, a per-transfer wait-state timeout, and decode-error responses are built in. Sits in the verification fabric between the master BFM and the peripheral models. It replaces two-clock bridging where master and slaves share a clock.

## Interface
Parameters:
- ADDR_W, 32, address width, both ports.
- DATA_W, 32, data width, both ports.
- NSLOTS, 16, number of downstream slots, 1..16.
- SEL_LSB, 24, LSB of the 4-bit slot field in the address; slot = PADDR_PM[SEL_LSB+3:SEL_LSB].
- SLOT_EN, 16'hFFFF, per-slot enable mask; a disabled slot decodes as unmapped.
- TIMEOUT, 255, ACCESS cycles without PREADY_SC before abort; 0 disables.
- TPD, 1, output delay (ns) on all downstream outputs.

Ports:
- PCLK  in  1  single clock, both sides.
- PRESET  in  1  synchronous active-high reset (decided: one clock, sync active-high reset).
- PSEL_PM, PENABLE_PM, PWRITE_PM  in  1 each  upstream APB controls.
- PADDR_PM  in  ADDR_W  upstream address.
- PWDATA_PM  in  DATA_W  upstream write data.
- PRDATA_PM  out  DATA_W  upstream read data, registered.
- PREADY_PM, PSLVERR_PM  out  1 each  upstream response, registered.
- PSEL_SC  out  NSLOTS  one-hot downstream select.
- PADDR_SC  out  ADDR_W  downstream address, full address passed through.
- PWRITE_SC, PENABLE_SC  out  1 each  downstream controls.
- PWDATA_SC  out  DATA_W  downstream write data.
- PRDATA_SC  in  NSLOTS*DATA_W  slot s read data at [s*DATA_W +: DATA_W].
- PREADY_SC, PSLVERR_SC  in  NSLOTS each  per-slot response.
- TIMEOUT_O, DECERR_O  out  1 each  one-cycle event pulses.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: on an edge sampling PSEL_PM=1 and PENABLE_PM=0, latch address, write flag and write data, then decode the slot.
  - Valid slot (< NSLOTS and SLOT_EN bit set): go to SETUP.
  - Otherwise: go to RESP with PSLVERR_PM=1, PRDATA_PM=0, and pulse DECERR_O.
- SETUP: PSEL_SC[slot]=1, PENABLE_SC=0, address/write/data driven. Next edge goes to ACCESS.
- ACCESS: PENABLE_SC=1.
  - On an edge with PREADY_SC[slot]=1: capture PRDATA_SC slice and PSLVERR_SC[slot], then go to RESP.
  - Otherwise increment the wait counter (width ceil(log2(TIMEOUT+1))).
  - When TIMEOUT>0 and the counter reaches TIMEOUT-1 with PREADY_SC still low, abort: go to RESP with PSLVERR_PM=1, PRDATA_PM=0, and pulse TIMEOUT_O.
- RESP: PREADY_PM=1 for exactly one cycle, all downstream outputs zero, then back to IDLE. The wait counter clears.
- Downstream address, data, write and select outputs are all-zero whenever the FSM is outside SETUP/ACCESS.
- PRDATA_PM, PSLVERR_PM hold their last value until the next RESP; PREADY_PM is low outside RESP.
- Upstream protocol violation (PSEL_PM dropped mid-transfer): the downstream transfer still completes, RESP still fires, and the result is discarded by the master.
- A new upstream setup phase is ignored unless the FSM is in IDLE.

## Timing
- Reset value of every output is 0; the FSM resets to IDLE. Reset mid-transfer drops the downstream PSEL_SC and PENABLE_SC on the next edge.
- Edge E0 samples the upstream setup.
  - After E0: downstream setup phase.
  - After E1: PENABLE_SC=1.
  - If PREADY_SC is high at E2: after E2, PREADY_PM=1 with data; the upstream transfer completes at E3.
- Minimum upstream latency is 3 access cycles. Each downstream wait cycle adds one.
- Decode error: PREADY_PM=1 after E0, so the upstream completes at E1.
- Timeout with TIMEOUT=T: PREADY_SC is sampled low on T ACCESS edges, E2..E(T+1). Abort happens on E(T+1), and PREADY_PM is high in the following cycle.
- Back-to-back: the next upstream setup may be sampled on the edge after the RESP cycle.

## Structure
- Package bfm_apb_pkg holds:
  - the state enum (2 bits);
  - the SLOT_W=4 constant;
  - a clog2 function for the counter width.
- One sub-module, bfm_apb_wait_timer: the wait-cycle counter with clear/enable and a terminal-count flag, disabled when TIMEOUT=0.
- Slot mux and decode are inline.

## Test plan
- Write 0x0300_0010, data 0xDEADBEEF, slot 3 PREADY held high -> PSEL_SC=0x0008 for 2 cycles, PWDATA_SC=0xDEADBEEF, PREADY_PM after E2, PSLVERR_PM=0.
- Read slot 5 with 2 wait states, PRDATA_SC[5]=0x12345678 -> PRDATA_PM=0x12345678 after E4, and no other PSEL_SC bit ever high.
- NSLOTS=4, address 0x0700_0000 -> no PSEL_SC activity, PREADY_PM+PSLVERR_PM after E0, DECERR_O pulse, PRDATA_PM=0.
- TIMEOUT=4, slot 1 never ready -> abort at E5, TIMEOUT_O pulse, PSLVERR_PM=1, PSEL_SC=0 after E5, with the next transfer accepted normally.
- PRESET asserted while in ACCESS -> all outputs 0 next cycle, FSM IDLE, and the following transfer completes with correct data.
- Slave returns PSLVERR_SC=1 on a write -> PSLVERR_PM=1 in RESP, with no TIMEOUT_O or DECERR_O.
